// File: rtl/cmp_arbiter.sv
// cmp_arbiter: four-requester round-robin arbiter that runs one unsigned
// 4-bit magnitude compare for the granted requester, four cycles per op.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[3:0]   compare request, bit i = requester i
//   a_in[15:0] operand A, requester i on bits [4i+3:4i]
//   b_in[15:0] operand B, same packing as a_in
//   gnt[3:0]   registered one-hot grant, held GRANT..DONE
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse, gt/eq/lt valid for granted requester
//   gt/eq/lt   registered A>B, A==B, A<B of the last compare
//   cmp_count  8-bit completed-compare counter, wraps 255->0
//              (present only when CMP_ARB_STATS_EN is defined)
//
// Build option: define CMP_ARB_STATS_EN to add the cmp_count port.

module cmp_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [15:0] a_in,
   input  logic [15:0] b_in,
   output logic [3:0]  gnt,
   output logic        busy,
   output logic        done,
   output logic        gt,
   output logic        eq,
   output logic        lt
`ifdef CMP_ARB_STATS_EN
   ,
   output logic [7:0]  cmp_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  gnt_q, gnt_d;
   logic        done_q, done_d;
   logic        gt_q, gt_d;
   logic        eq_q, eq_d;
   logic        lt_q, lt_d;
   logic [1:0]  last_q, last_d;
   logic [1:0]  win_q, win_d;
   logic [3:0]  a_q, a_d;
   logic [3:0]  b_q, b_d;
`ifdef CMP_ARB_STATS_EN
   logic [7:0]  cnt_q, cnt_d;
`endif

   // Round-robin pick: scan from last+1 upward, wrapping 3->0, so the
   // most recently served requester is considered last.
   logic [1:0]  pick;
   logic [1:0]  idx;
   logic        found;

   always_comb begin
      pick  = last_q + 2'd1;
      idx   = 2'd0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = last_q + 2'(k + 1);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = done_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      last_d  = last_q;
      win_d   = win_q;
      a_d     = a_q;
      b_d     = b_q;
`ifdef CMP_ARB_STATS_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_GRANT;
               gnt_d   = 4'b0001 << pick;
               win_d   = pick;
               a_d     = a_in[4*pick +: 4];
               b_d     = b_in[4*pick +: 4];
            end else begin
               gnt_d   = 4'b0000;
            end
         end
         S_GRANT: begin
            state_d = S_COMPARE;
            gt_d    = (a_q >  b_q);
            eq_d    = (a_q == b_q);
            lt_d    = (a_q <  b_q);
         end
         S_COMPARE: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            last_d  = win_q;
`ifdef CMP_ARB_STATS_EN
            cnt_d   = cnt_q + 8'd1;
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            done_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            done_d  = 1'b0;
         end
      endcase
   end

   // last resets to 3 so requester 0 holds first priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 4'b0000;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         last_q  <= 2'd3;
         win_q   <= 2'd0;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
`ifdef CMP_ARB_STATS_EN
         cnt_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         last_q  <= last_d;
         win_q   <= win_d;
         a_q     <= a_d;
         b_q     <= b_d;
`ifdef CMP_ARB_STATS_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign gt   = gt_q;
   assign eq   = eq_q;
   assign lt   = lt_q;
`ifdef CMP_ARB_STATS_EN
   assign cmp_count = cnt_q;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: self-checking bench for cmp_arbiter; table of single
// compares plus fairness, mid-op reset and (optional) counter sequences.

module tb_cmp_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic        gt;
   logic        eq;
   logic        lt;
`ifdef CMP_ARB_STATS_EN
   logic [7:0]  cmp_count;
`endif

   cmp_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .busy      (busy),
      .done      (done),
      .gt        (gt),
      .eq        (eq),
      .lt        (lt)
`ifdef CMP_ARB_STATS_EN
      ,
      .cmp_count (cmp_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // expected {gnt, gt, eq, lt} for each done pulse, in order
   logic [6:0] sb[$];

   function automatic void check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // scoreboard: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            check("done_result", {gnt, gt, eq, lt}, sb.pop_front());
         end
      end
   end

   typedef struct {
      logic [3:0] req;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] gnt;
      logic [2:0] res;
   } vec_t;

   vec_t tbl[10];

   task automatic do_reset(input logic [3:0] r);
      @(negedge clk);
      rst = 1'b1;
      req = r;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0000;
   endtask

   // One full compare; operands of losing slots are swapped garbage,
   // and all inputs are scrambled right after the latch edge.
   task automatic run_op(input logic [3:0] r, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] eg,
                         input logic [2:0] er);
      logic [15:0] pa;
      logic [15:0] pb;
      @(negedge clk);
      pa = {4{b}};
      pb = {4{a}};
      for (int i = 0; i < 4; i++) begin
         if (eg[i]) begin
            pa[4*i +: 4] = a;
            pb[4*i +: 4] = b;
         end
      end
      req  = r;
      a_in = pa;
      b_in = pb;
      sb.push_back({eg, er});
      @(negedge clk);
      check("gnt", gnt, eg);
      check("busy", busy, 1);
      req  = 4'b0000;
      a_in = ~pa;
      b_in = ~pb;
      @(negedge clk);
      check("gnt_hold1", gnt, eg);
      check("done_early", done, 0);
      @(negedge clk);
      check("done_lat", done, 1);
      check("gnt_hold2", gnt, eg);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("gnt_idle", gnt, 0);
      check("busy_idle", busy, 0);
      check("res_hold", {gt, eq, lt}, er);
   endtask

   initial begin
      tbl[0] = '{4'b0100, 4'h9, 4'h6, 4'b0100, 3'b100};
      tbl[1] = '{4'b0001, 4'hA, 4'hA, 4'b0001, 3'b010};
      tbl[2] = '{4'b0001, 4'h3, 4'hC, 4'b0001, 3'b001};
      tbl[3] = '{4'b1010, 4'h7, 4'h7, 4'b0010, 3'b010};
      tbl[4] = '{4'b1010, 4'h0, 4'hF, 4'b1000, 3'b001};
      tbl[5] = '{4'b1111, 4'hF, 4'h0, 4'b0001, 3'b100};
      tbl[6] = '{4'b0011, 4'h8, 4'h4, 4'b0010, 3'b100};
      tbl[7] = '{4'b1000, 4'h0, 4'h0, 4'b1000, 3'b010};
      tbl[8] = '{4'b0101, 4'h2, 4'h3, 4'b0001, 3'b001};
      tbl[9] = '{4'b0101, 4'hC, 4'hB, 4'b0100, 3'b100};

      rst  = 1'b1;
      req  = 4'b1111;
      a_in = 16'h0;
      b_in = 16'h0;

      // reset with all requests high
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", {gt, eq, lt}, 0);
      rst = 1'b0;
      req = 4'b0000;

      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].req, tbl[i].a, tbl[i].b,
                tbl[i].gnt, tbl[i].res);
      end

      // fairness: all four requesting for 20 cycles
      do_reset(4'b0000);
      @(negedge clk);
      req  = 4'b1111;
      a_in = {4'hF, 4'h1, 4'h2, 4'h5};
      b_in = {4'hE, 4'h9, 4'h2, 4'h2};
      sb.push_back({4'b0001, 3'b100});
      sb.push_back({4'b0010, 3'b010});
      sb.push_back({4'b0100, 3'b001});
      sb.push_back({4'b1000, 3'b100});
      sb.push_back({4'b0001, 3'b100});
      for (int k = 1; k <= 20; k++) begin
         logic [3:0] eg;
         @(negedge clk);
         eg = 4'b0000;
         if (((k - 1) % 4) < 3) eg[((k - 1) / 4) % 4] = 1'b1;
         check($sformatf("fair_gnt_%0d", k), gnt, eg);
      end
      req = 4'b0000;

      // reset during COMPARE, then a normal op
      do_reset(4'b0000);
      @(negedge clk);
      req  = 4'b0001;
      a_in = 16'h0005;
      b_in = 16'h0001;
      @(negedge clk);
      check("mid_gnt", gnt, 4'b0001);
      req = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_gnt0", gnt, 0);
      check("mid_done", done, 0);
      check("mid_busy", busy, 0);
      check("mid_res", {gt, eq, lt}, 0);
      rst = 1'b0;
      run_op(4'b0010, 4'h6, 4'h6, 4'b0010, 3'b010);

`ifdef CMP_ARB_STATS_EN
      do_reset(4'b0000);
      check("cnt_rst", cmp_count, 0);
      for (int i = 0; i < 256; i++) begin
         logic [3:0] a;
         logic [3:0] b;
         logic [7:0] iv;
         iv = 8'(i);
         a  = iv[3:0];
         b  = iv[7:4];
         run_op(4'b0001, a, b, 4'b0001, {a > b, a == b, a < b});
         if (i == 254) check("cnt_255", cmp_count, 255);
         if (i == 255) check("cnt_wrap", cmp_count, 0);
      end
`endif

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: req  input  4  per-requester compare request, bit i = requester i.
REQ-005 SHALL have port: a_in  input  16  packed operand A; requester i drives bits [4i+3:4i].
REQ-006 SHALL have port: b_in  input  16  packed operand B; same packing as a_in.
REQ-007 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-008 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; gt/eq/lt valid for granted requester.
REQ-010 SHALL have ports: gt, eq, lt  output  1 each  registered unsigned A>B, A==B, A<B.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, COMPARE, DONE.
REQ-012 In IDLE with req != 0 at a clock edge: select winner w round-robin, latch A_w/B_w, move to GRANT, set gnt = onehot(w).
- Round-robin search starts at (last+1) mod 4, wraps 3->0.
REQ-013 In IDLE with req == 0: stay in IDLE, gnt = 0.
REQ-014 GRANT -> COMPARE unconditionally; gt/eq/lt registered from the latched operands on this edge.
REQ-015 COMPARE -> DONE unconditionally; done = 1 and last = w on this edge.
REQ-016 DONE -> IDLE unconditionally; gnt = 0 and done = 0 on this edge.
REQ-017 Latency SHALL be fixed:
- gnt asserted 1 cycle after the req-sampling edge;
- done asserted 2 cycles after the gnt edge;
- throughput SHALL be one compare per 4 cycles.
REQ-018 Exactly one of gt/eq/lt SHALL be high from the first compare onward; the values SHALL hold until the next compare overwrites them.
REQ-019 Operands SHALL be unsigned 4-bit; a_in/b_in changes after the latch edge SHALL NOT affect the result.
REQ-020 Deasserting req[w] after grant SHALL NOT abort the operation; done still pulses.
REQ-021 A requester still holding req in IDLE after its done SHALL be re-arbitrated, behind other pending requesters.
REQ-022 req bits of non-granted requesters SHALL be ignored while busy.
REQ-023 gnt SHALL stay stable and one-hot from GRANT through DONE.

Reset
REQ-024 On rst high at a clock edge:
- state = IDLE; gnt = 0; busy = 0; done = 0; gt = eq = lt = 0;
- last = 3, so requester 0 has first priority.
REQ-025 rst SHALL take precedence in every state; reset mid-operation SHALL produce no done pulse.

Configuration
REQ-026 With CMP_ARB_STATS_EN defined, the block SHALL add output port cmp_count (8 bits).
- Reset value 0; increments on every COMPARE->DONE edge.
- Wraps 255->0.
REQ-027 Without CMP_ARB_STATS_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Bench SHALL cover reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, done=0, gt=eq=lt=0.
REQ-029 Bench SHALL cover a single requester: req=4'b0100, A2=4'b1001, B2=4'b0110 -> next edge gnt=4'b0100; 2 edges later done=1, gt=1, eq=0, lt=0.
REQ-030 Bench SHALL cover equal and less-than cases:
- req=4'b0001, A0=B0=4'hA -> eq=1 at done;
- A0=4'h3, B0=4'hC -> lt=1 at done.
REQ-031 Bench SHALL cover fairness: req=4'b1111 held for 20 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with gnt=0 for one IDLE cycle between grants.
REQ-032 Bench SHALL cover reset mid-operation: rst=1 during COMPARE -> next edge state IDLE, gnt=0, no done pulse; the subsequent req=4'b0010 is served normally.
REQ-033 With CMP_ARB_STATS_EN defined, the bench SHALL run 256 completed compares -> cmp_count reads 255 after the 255th done and 0 after the 256th.
